// File: rtl/gaze_sequencer_if.sv
// ============================================================================
// Module      : gaze_sequencer_if
// Description : Angle-pair valid/ready bus between the gaze sequencer and the
//               pan/tilt servo drivers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface gaze_sequencer_if;
    logic [7:0] angle_x;
    logic [7:0] angle_y;
    logic       angle_valid;
    logic       angle_ready;

    modport master (
        output angle_x,
        output angle_y,
        output angle_valid,
        input  angle_ready
    );

    modport slave (
        input  angle_x,
        input  angle_y,
        input  angle_valid,
        output angle_ready
    );
endinterface

`default_nettype wire

// File: rtl/gaze_sequencer.sv
// ============================================================================
// Module      : gaze_sequencer
// Description : Pan/tilt gaze controller: arbitrates manual, scan and centre
//               motion, slew-limits both axes, presents X/Y via valid/ready.
//               Optional macro GAZE_SNAP_EN: CENTER loads the centre pair in
//               one step instead of slewing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gaze_sequencer #(
    parameter int ANGLE_MAX    = 180,
    parameter int ANGLE_CENTER = 90,
    parameter int STEP_DIV     = 10,
    parameter int IDLE_TIMEOUT = 3000,
    parameter int SCAN_MIN     = 30,
    parameter int SCAN_MAX     = 150
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       tick,
    input  wire logic       left_dir,
    input  wire logic       right_dir,
    input  wire logic       up_dir,
    input  wire logic       down_dir,
    input  wire logic       scan_en,
    input  wire logic       center_req,
    gaze_sequencer_if.master bus,
    output logic [2:0]      state
);

    localparam int STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);

    localparam logic [STEP_W-1:0] c_step_last  = STEP_W'(STEP_DIV - 1);
    localparam logic [IDLE_W-1:0] c_idle_max   = IDLE_W'(IDLE_TIMEOUT);
    localparam logic [7:0]        c_angle_max  = 8'(ANGLE_MAX);
    localparam logic [7:0]        c_center     = 8'(ANGLE_CENTER);
    localparam logic [7:0]        c_scan_min   = 8'(SCAN_MIN);
    localparam logic [7:0]        c_scan_max   = 8'(SCAN_MAX);

    typedef enum logic [2:0] {
        S_HOLD   = 3'd0,
        S_MANUAL = 3'd1,
        S_SCAN   = 3'd2,
        S_CENTER = 3'd3
    } state_t;

    state_t              state_q, state_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [IDLE_W-1:0]   idle_q, idle_d;
    logic [7:0]          x_q, x_d;
    logic [7:0]          y_q, y_d;
    logic                valid_q, valid_d;
    logic                scan_up_q, scan_up_d;

    logic w_any_dir;
    logic w_step_evt;
    logic w_accept;
    logic w_idle_full;
    logic w_state_chg;
    logic w_changed;

    function automatic logic [7:0] slew_to(input logic [7:0] cur, input logic [7:0] tgt);
        if (cur < tgt)
            return cur + 8'd1;
        else if (cur > tgt)
            return cur - 8'd1;
        else
            return cur;
    endfunction

    always_comb begin
        w_any_dir   = left_dir | right_dir | up_dir | down_dir;
        w_step_evt  = tick && (step_q == c_step_last);
        w_accept    = !valid_q || bus.angle_ready;
        w_idle_full = (idle_q == c_idle_max);

        state_d = state_q;
        case (state_q)
            S_HOLD: begin
                if (center_req)                  state_d = S_CENTER;
                else if (w_any_dir)              state_d = S_MANUAL;
                else if (scan_en && w_idle_full) state_d = S_SCAN;
            end
            S_MANUAL: begin
                if (center_req)                  state_d = S_CENTER;
                else if (!w_any_dir && w_idle_full)
                    state_d = scan_en ? S_SCAN : S_HOLD;
            end
            S_SCAN: begin
                if (center_req)                  state_d = S_CENTER;
                else if (w_any_dir)              state_d = S_MANUAL;
                else if (!scan_en)               state_d = S_HOLD;
            end
            S_CENTER: begin
                if (!center_req && (x_q == c_center) && (y_q == c_center))
                    state_d = S_HOLD;
            end
            default: state_d = S_HOLD;
        endcase
        w_state_chg = (state_d != state_q);

        step_d = step_q;
        if (w_state_chg)
            step_d = '0;
        else if (tick)
            step_d = (step_q == c_step_last) ? '0 : step_q + 1'b1;

        idle_d = idle_q;
        if (w_state_chg || w_any_dir)
            idle_d = '0;
        else if (tick && !w_idle_full && (state_q == S_HOLD || state_q == S_MANUAL))
            idle_d = idle_q + 1'b1;

        // Motion only on an accepted step; a pending unconsumed pair freezes both axes.
        x_d       = x_q;
        y_d       = y_q;
        scan_up_d = scan_up_q;
        if (w_step_evt && w_accept && !w_state_chg) begin
            case (state_q)
                S_MANUAL: begin
                    if (right_dir && !left_dir && x_q < c_angle_max)  x_d = x_q + 8'd1;
                    else if (left_dir && !right_dir && x_q != 8'd0)   x_d = x_q - 8'd1;
                    if (up_dir && !down_dir && y_q < c_angle_max)     y_d = y_q + 8'd1;
                    else if (down_dir && !up_dir && y_q != 8'd0)      y_d = y_q - 8'd1;
                end
                S_SCAN: begin
                    y_d = slew_to(y_q, c_center);
                    // Reverse on the step that lands on a bound so it is emitted once.
                    if (x_q < c_scan_min) begin
                        x_d = x_q + 8'd1;
                        if (x_d == c_scan_min) scan_up_d = 1'b1;
                    end else if (x_q > c_scan_max) begin
                        x_d = x_q - 8'd1;
                        if (x_d == c_scan_max) scan_up_d = 1'b0;
                    end else if (scan_up_q) begin
                        if (x_q == c_scan_max) begin
                            x_d       = x_q - 8'd1;
                            scan_up_d = 1'b0;
                        end else begin
                            x_d = x_q + 8'd1;
                            if (x_d == c_scan_max) scan_up_d = 1'b0;
                        end
                    end else begin
                        if (x_q == c_scan_min) begin
                            x_d       = x_q + 8'd1;
                            scan_up_d = 1'b1;
                        end else begin
                            x_d = x_q - 8'd1;
                            if (x_d == c_scan_min) scan_up_d = 1'b1;
                        end
                    end
                end
                S_CENTER: begin
`ifdef GAZE_SNAP_EN
                    x_d = c_center;
                    y_d = c_center;
`else
                    x_d = slew_to(x_q, c_center);
                    y_d = slew_to(y_q, c_center);
`endif
                end
                default: ;
            endcase
        end

        w_changed = (x_d != x_q) || (y_d != y_q);
        if (w_changed)
            valid_d = 1'b1;
        else if (valid_q && bus.angle_ready)
            valid_d = 1'b0;
        else
            valid_d = valid_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_HOLD;
            step_q    <= '0;
            idle_q    <= '0;
            x_q       <= c_center;
            y_q       <= c_center;
            valid_q   <= 1'b1;
            scan_up_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            idle_q    <= idle_d;
            x_q       <= x_d;
            y_q       <= y_d;
            valid_q   <= valid_d;
            scan_up_q <= scan_up_d;
        end
    end

    assign bus.angle_x     = x_q;
    assign bus.angle_y     = y_q;
    assign bus.angle_valid = valid_q;
    assign state           = state_q;

endmodule

`default_nettype wire

// File: tb/tb_gaze_sequencer.sv
// ============================================================================
// Module      : tb_gaze_sequencer
// Description : Scoreboard bench for gaze_sequencer: expected angle pairs are
//               queued with each stimulus and popped on every handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gaze_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       left_dir, right_dir, up_dir, down_dir;
    logic       scan_en, center_req;
    logic [2:0] state;

    gaze_sequencer_if bus_if ();

    gaze_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .left_dir   (left_dir),
        .right_dir  (right_dir),
        .up_dir     (up_dir),
        .down_dir   (down_dir),
        .scan_en    (scan_en),
        .center_req (center_req),
        .bus        (bus_if),
        .state      (state)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One-clk tick every other cycle.
    initial begin
        tick = 1'b0;
        forever begin
            @(posedge clk);
            #1 tick = ~tick;
        end
    end

    // Every accepted pair must match the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus_if.angle_valid && bus_if.angle_ready) begin
                if (exp_q.size() == 0)
                    check("xfer_unexpected", 32'({bus_if.angle_x, bus_if.angle_y}), 32'hFFFF_FFFF);
                else
                    check("xfer", 32'({bus_if.angle_x, bus_if.angle_y}), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            while (!tick) @(negedge clk);
        end
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
        int cyc = 0;
        while (state != s && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        check(tag, 32'(state), 32'(s));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] cx, cy;
        int         cyc;

        rst = 1'b1;
        left_dir = 0; right_dir = 0; up_dir = 0; down_dir = 0;
        scan_en = 0; center_req = 0;
        bus_if.angle_ready = 1'b0;

        // Reset: centre pair presented and held until consumed.
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_x", 32'(bus_if.angle_x), 32'd90);
        check("rst_y", 32'(bus_if.angle_y), 32'd90);
        check("rst_valid", 32'(bus_if.angle_valid), 32'd1);
        check("rst_state", 32'(state), 32'd0);
        repeat (5) @(negedge clk);
        check("rst_valid_held", 32'(bus_if.angle_valid), 32'd1);
        exp_q.push_back({8'd90, 8'd90});
        @(posedge clk);
        #1 bus_if.angle_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_valid_drop", 32'(bus_if.angle_valid), 32'd0);
        check("rst_drain", 32'(exp_q.size()), 32'd0);

        // Manual saturate at ANGLE_MAX.
        for (int i = 91; i <= 180; i++) exp_q.push_back({8'(i), 8'd90});
        @(posedge clk);
        #1 right_dir = 1'b1;
        wait_ticks(1000);
        check("sat_x", 32'(bus_if.angle_x), 32'd180);
        check("sat_y", 32'(bus_if.angle_y), 32'd90);
        check("sat_state", 32'(state), 32'd1);
        check("sat_drain", 32'(exp_q.size()), 32'd0);

        // Opposing X inputs cancel; Y climbs 5 steps in 50 ticks.
        for (int i = 91; i <= 95; i++) exp_q.push_back({8'd180, 8'(i)});
        @(posedge clk);
        #1 begin left_dir = 1'b1; right_dir = 1'b1; up_dir = 1'b1; end
        wait_ticks(50);
        @(posedge clk);
        #1 begin left_dir = 1'b0; right_dir = 1'b0; up_dir = 1'b0; end
        wait_drain("opp_drain", 100);
        check("opp_x", 32'(bus_if.angle_x), 32'd180);
        check("opp_y", 32'(bus_if.angle_y), 32'd95);

        // Backpressure: first step held frozen, later steps discarded.
        for (int i = 179; i >= 176; i--) exp_q.push_back({8'(i), 8'd95});
        @(posedge clk);
        #1 begin bus_if.angle_ready = 1'b0; left_dir = 1'b1; end
        wait_ticks(50);
        check("bp_x_frozen", 32'(bus_if.angle_x), 32'd179);
        check("bp_valid", 32'(bus_if.angle_valid), 32'd1);
        @(posedge clk);
        #1 bus_if.angle_ready = 1'b1;
        wait_ticks(30);
        @(posedge clk);
        #1 left_dir = 1'b0;
        wait_drain("bp_drain", 100);
        check("bp_x_end", 32'(bus_if.angle_x), 32'd176);

        // Centre request beats a held direction; slews to 90/90.
        cx = 8'd176; cy = 8'd95;
`ifdef GAZE_SNAP_EN
        exp_q.push_back({8'd90, 8'd90});
`else
        while (cx != 8'd90 || cy != 8'd90) begin
            if (cx > 8'd90) cx--; else if (cx < 8'd90) cx++;
            if (cy > 8'd90) cy--; else if (cy < 8'd90) cy++;
            exp_q.push_back({cx, cy});
        end
`endif
        @(posedge clk);
        #1 begin left_dir = 1'b1; center_req = 1'b1; end
        @(posedge clk);
        #1 center_req = 1'b0;
        @(negedge clk);
        check("ctr_state", 32'(state), 32'd3);
        cyc = 0;
        while (state == 3'd3 && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        check("ctr_exit_hold", 32'(state), 32'd0);
        @(negedge clk);
        check("ctr_then_manual", 32'(state), 32'd1);
        @(posedge clk);
        #1 begin left_dir = 1'b0; scan_en = 1'b1; end
        wait_drain("ctr_drain", 10);
        check("ctr_x", 32'(bus_if.angle_x), 32'd90);

        // Idle timeout into scan: up to 150, down to 30, back up to 40.
        for (int i = 91; i <= 150; i++)      exp_q.push_back({8'(i), 8'd90});
        for (int i = 149; i >= 30; i--)      exp_q.push_back({8'(i), 8'd90});
        for (int i = 31; i <= 40; i++)       exp_q.push_back({8'(i), 8'd90});
        wait_state("scan_state", 3'd2, 8000);
        wait_drain("scan_drain", 6000);
        @(posedge clk);
        #1 scan_en = 1'b0;
        repeat (2) @(negedge clk);
        check("scan_off_state", 32'(state), 32'd0);
        check("scan_off_x", 32'(bus_if.angle_x), 32'd40);

        // Reset with a pair pending: it is dropped and the centre pair returns.
        @(posedge clk);
        #1 begin bus_if.angle_ready = 1'b0; right_dir = 1'b1; end
        wait_ticks(15);
        check("rmid_pending_x", 32'(bus_if.angle_x), 32'd41);
        check("rmid_pending_valid", 32'(bus_if.angle_valid), 32'd1);
        @(posedge clk);
        #1 begin rst = 1'b1; right_dir = 1'b0; end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rmid_x", 32'(bus_if.angle_x), 32'd90);
        check("rmid_y", 32'(bus_if.angle_y), 32'd90);
        check("rmid_valid", 32'(bus_if.angle_valid), 32'd1);
        check("rmid_state", 32'(state), 32'd0);
        exp_q.push_back({8'd90, 8'd90});
        @(posedge clk);
        #1 bus_if.angle_ready = 1'b1;
        wait_drain("rmid_drain", 10);

        repeat (20) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/gaze_sequencer.md
Name: gaze_sequencer

Overview:
Pan/tilt gaze controller that sits between the four direction buttons and the two sg90 servo drivers (X = pan, Y = tilt).
- Arbitrates between manual direction input, an autonomous horizontal scan, and a centre request.
- Slew-limits both angles and presents the X/Y targets to the servo drivers through a valid/ready handshake.
- Replaces direct direction-to-angle conversion so the eyes never jump and drift into a scan when left idle.

Parameters:
ANGLE_MAX, 180, maximum legal angle in degrees; both axes clamp to 0..ANGLE_MAX
ANGLE_CENTER, 90, centre/reset angle for both axes
STEP_DIV, 10, tick strobes per 1-degree slew step
IDLE_TIMEOUT, 3000, ticks with no direction input before leaving MANUAL
SCAN_MIN, 30, lower X bound of autonomous scan
SCAN_MAX, 150, upper X bound of autonomous scan

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
tick  input  1  one-clk-wide strobe at 1 kHz, synchronous to clk
left_dir  input  1  manual X decrement request, level
right_dir  input  1  manual X increment request, level
up_dir  input  1  manual Y increment request, level
down_dir  input  1  manual Y decrement request, level
scan_en  input  1  enables autonomous scan on idle timeout
center_req  input  1  level; slew both axes to ANGLE_CENTER
angle_x  output  8  X target angle to servo driver
angle_y  output  8  Y target angle to servo driver
angle_valid  output  1  angle_x/angle_y hold a new, unconsumed pair
angle_ready  input  1  servo side accepts pair when high with angle_valid
state  output  3  encoded FSM state: 0 HOLD, 1 MANUAL, 2 SCAN, 3 CENTER

Behaviour:
- Clock and reset: one clock (clk); rst is synchronous and active-high.
- All logic is on posedge clk. rst is sampled there and overrides everything.
- Reset values:
  - state = HOLD; angle_x = angle_y = ANGLE_CENTER; angle_valid = 1 (pushes the centre pair).
  - Step counter = 0; idle counter = 0; scan direction = up.
- Step event: tick high and step counter == STEP_DIV-1. The counter then wraps to 0. The counter only advances on tick. It clears on every state change.
- Handshake:
  - Transfer occurs when angle_valid and angle_ready are both high; angle_valid drops the next cycle unless a new step is produced in that same cycle.
  - While angle_valid=1 and angle_ready=0, angle_x/angle_y are frozen and step events are discarded; the counter still wraps.
  - A step that changes either angle sets angle_valid=1 on the following cycle.
  - A step that leaves both angles unchanged does not assert angle_valid.
- Priority when selecting the next state, highest first: center_req > any direction input > idle timeout.
- HOLD:
  - No motion.
  - center_req -> CENTER.
  - Any dir -> MANUAL.
  - scan_en=1 and idle counter reaches IDLE_TIMEOUT -> SCAN.
- MANUAL:
  - Per step event, X +1 if right_dir only, -1 if left_dir only, unchanged if both or neither. Y is handled the same way with up_dir/down_dir.
  - Both axes are saturating: no wrap below 0 or above ANGLE_MAX.
  - Idle counter clears on any dir and counts ticks otherwise.
  - On reaching IDLE_TIMEOUT: -> SCAN if scan_en, else -> HOLD.
  - center_req -> CENTER.
- SCAN:
  - Y slews 1 deg/step toward ANGLE_CENTER.
  - X moves 1 deg/step in the scan direction and reverses on reaching SCAN_MAX or SCAN_MIN. The reversal occurs on the step that lands on the bound; the bound value is emitted once.
  - If X starts outside SCAN_MIN..SCAN_MAX, it slews toward the nearest bound first.
  - Any dir -> MANUAL, same cycle, with the idle counter cleared.
  - scan_en=0 -> HOLD.
- CENTER:
  - Both axes slew 1 deg/step toward ANGLE_CENTER.
  - When both equal ANGLE_CENTER and center_req=0 -> HOLD.
  - While center_req stays high, remain in CENTER and ignore direction inputs.
- Idle counter: counts ticks in HOLD and MANUAL, saturates at IDLE_TIMEOUT, and clears on any dir, on any state change, and on reset.
- Latency: a dir asserted before a tick reaches angle_x/angle_y at most STEP_DIV ticks + 1 clk later.
- Reset mid-handshake: the pending pair is discarded and the centre pair is re-presented.

Optional Feature:
GAZE_SNAP_EN
- Defined: on entering CENTER, angle_x/angle_y are loaded with ANGLE_CENTER on the first step event (a single handshake transfer), then -> HOLD once center_req=0.
- Undefined: CENTER slews at 1 deg/step exactly as described above.

Test Plan:
- Reset:
  - Stimulus: rst high 3 clk, angle_ready=0, then release.
  - Expected: angle_x=90, angle_y=90, angle_valid=1 held; state=0; angle_ready=1 -> valid drops next clk.
- Manual saturate:
  - Stimulus: right_dir held 1000 ticks, STEP_DIV=10.
  - Expected: angle_x steps 90 -> 180 after 90 steps and stays 180; angle_y stays 90; no valid on steps after saturation.
- Opposing inputs:
  - Stimulus: left_dir and right_dir both high, up_dir high for 50 ticks.
  - Expected: angle_x unchanged; angle_y 90 -> 95.
- Idle to scan:
  - Stimulus: scan_en=1, no dir for 3000 ticks from MANUAL.
  - Expected: state=2; X sweeps to 150, reverses, reaches 30, reverses; 150 and 30 each appear once per sweep.
- Centre priority:
  - Stimulus: from X=120/Y=60, center_req pulses 1 clk while left_dir is held.
  - Expected: state=3; 30 steps to 90/90; then state=0 then 1 (left_dir still held).
- Backpressure:
  - Stimulus: MANUAL right_dir, angle_ready=0 for 50 ticks.
  - Expected: angle_x frozen at first new value 91; on ready=1, one transfer then stepping resumes.
